// File: rtl/step_sequencer_pkg.sv
// Shared CPU constants: sequencer state encoding and the default halt opcode.
package step_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_e;

    localparam logic [7:0] HLT_OPCODE_DEFAULT = 8'hFF;
    localparam int         INSTR_COUNT_WIDTH  = 8;

endpackage

// File: rtl/step_sequencer_counter.sv
// T-state up-counter with synchronous clear (priority over enable) and a
// terminal-count flag raised when the count sits at its all-ones value.
module step_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == '1);

endmodule

// File: rtl/step_sequencer.sv
// CPU T-state sequencer: FETCH (steps 0-1, opcode latch with memory stall),
// EXEC (steps 2..last, early end allowed), HALT until reset.
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int                   STEP_WIDTH = 3,
    parameter int                   OPC_WIDTH  = 8,
    parameter logic [OPC_WIDTH-1:0] HLT_OPCODE = OPC_WIDTH'(HLT_OPCODE_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OPC_WIDTH-1:0]  ir_in,
    input  logic                  mem_ready,
    input  logic                  end_instr,
    output logic [STEP_WIDTH-1:0] step,
    output logic                  step_en,
    output logic [OPC_WIDTH-1:0]  opcode,
    output logic                  fetch,
    output logic                  halted,
    output logic [INSTR_COUNT_WIDTH-1:0] instr_count
);

    seq_state_e                   state_q, state_d;
    logic [OPC_WIDTH-1:0]         opcode_q, opcode_d;
    logic [INSTR_COUNT_WIDTH-1:0] count_q, count_d;
    logic [STEP_WIDTH-1:0]        step_q;
    logic                         step_tc;
    logic                         cnt_clr;
    logic                         cnt_en;
    logic                         step_active;

    step_counter #(
        .WIDTH (STEP_WIDTH)
    ) u_step_counter (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (step_q),
        .tc_o    (step_tc)
    );

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        count_d     = count_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        step_active = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (step_q == '0) begin
                    step_active = 1'b1;
                    cnt_en      = 1'b1;
                end else if (mem_ready) begin
                    step_active = 1'b1;
                    opcode_d    = ir_in;
                    if (ir_in == HLT_OPCODE) begin
                        state_d = ST_HALT;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                        cnt_en  = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                step_active = 1'b1;
                // Last step and an early end collapse into one wrap and one count.
                if (step_tc || end_instr) begin
                    state_d = ST_FETCH;
                    cnt_clr = 1'b1;
                    count_d = count_q + INSTR_COUNT_WIDTH'(1);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_HALT: begin
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            opcode_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            count_q  <= count_d;
        end
    end

    // The stall at step 1 must drop the decoder enable in the same cycle
    // mem_ready is low, so the enable decodes registered state with live inputs.
    assign step_en     = step_active & ~reset;
    assign step        = step_q;
    assign opcode      = opcode_q;
    assign instr_count = count_q;
    assign fetch       = (state_q == ST_FETCH);
    assign halted      = (state_q == ST_HALT);

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter STEP_WIDTH, default 3: width of the T-state index; the last step is 2**STEP_WIDTH-1.
REQ-002 Parameter OPC_WIDTH, default 8: width of the opcode and instruction register.
REQ-003 Parameter HLT_OPCODE, default 8'hFF: opcode value that halts the sequencer.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ir_in  input  OPC_WIDTH  opcode from the data bus, sampled during step 1.
REQ-008 mem_ready  input  1  memory handshake; high means ir_in is valid this cycle.
REQ-009 end_instr  input  1  control-unit request to end the current instruction early.
REQ-010 step  output  STEP_WIDTH  current T-state index; drives the downstream decoder select.
REQ-011 step_en  output  1  decoder enable; high only when the current step is active.
REQ-012 opcode  output  OPC_WIDTH  latched instruction register.
REQ-013 fetch  output  1  high while in state FETCH.
REQ-014 halted  output  1  high while in state HALT.
REQ-015 instr_count  output  8  number of completed instructions, wrapping modulo 256.

Function
REQ-016 Three states: FETCH (step 0-1), EXEC (step 2 to last), HALT; all outputs registered.
REQ-017 FETCH step 0: step_en=1; step advances to 1 on the next edge unconditionally.
REQ-018 FETCH step 1, mem_ready=0: step holds at 1, step_en=0 (stall); stall length unbounded.
REQ-019 FETCH step 1, mem_ready=1: step_en=1; opcode<=ir_in at that edge; next step=2, state EXEC.
REQ-020 FETCH step 1, mem_ready=1 and ir_in==HLT_OPCODE: opcode<=ir_in; next state HALT; step<=0.
REQ-021 EXEC: step_en=1; step increments by 1 every cycle.
REQ-022 EXEC at last step (7 at default), or EXEC with end_instr=1: next step=0, state FETCH, instr_count+1.
REQ-023 end_instr together with the last step: single wrap to 0; instr_count increments once only.
REQ-024 end_instr is ignored in FETCH and HALT.
REQ-025 mem_ready is ignored outside FETCH step 1.
REQ-026 HALT: step=0, step_en=0, halted=1; opcode and instr_count hold; only reset exits HALT.
REQ-027 The halting instruction does not increment instr_count.
REQ-028 Latency: step 0 of the first instruction is presented in the first cycle after reset deasserts.

Reset
REQ-029 reset=1 at a clock edge: state FETCH, step=0, opcode=0, instr_count=0.
REQ-030 Output values after reset: fetch=1, halted=0, step_en=0 while reset=1, and step_en=1 in the first cycle after reset is released.
REQ-031 reset has priority over every other input, including a mid-stall, mid-EXEC or HALT condition; any partial instruction is discarded.

Structure
REQ-032 The state encoding (FETCH, EXEC, HALT) and the HLT_OPCODE default are defined as constants in the shared CPU include header.
REQ-033 The step counter is a natural sub-module, step_counter: a STEP_WIDTH up-counter with synchronous clear, enable and a terminal-count flag.
REQ-034 step feeds the existing decoder (WIDTH=STEP_WIDTH) select, and step_en feeds its EN, with no glue logic between them.

Verification
REQ-035 Reset, then ir_in=8'h01 with mem_ready held at 1 and no end_instr -> step 0,1,...,7,0; instr_count=1 after 8 cycles; opcode=8'h01.
REQ-036 mem_ready=0 for 3 cycles at step 1 -> step stays at 1 with step_en=0 for 3 cycles; opcode is latched on the cycle mem_ready rises.
REQ-037 end_instr pulsed at step 3 -> next step=0 and fetch=1; the instruction takes 4 cycles; instr_count increments by 1.
REQ-038 ir_in=8'hFF at step 1 with mem_ready=1 -> halted=1, step=0 and step_en=0 from the next cycle on; these hold for 20 cycles even if end_instr=1.
REQ-039 reset asserted at step 5 of EXEC and again during HALT -> the next cycle shows step=0, fetch=1, halted=0, opcode=0, instr_count=0.
REQ-040 256 one-step instructions (end_instr pulsed at step 2 of each) -> instr_count wraps from 255 to 0.
